// File: rtl/edit_ctrl_pkg.sv
// Shared types and constants for the time-of-day edit controller.
package edit_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        EDIT = 1'b1
    } state_e;

    localparam logic [2:0] POS_SEC_ONES = 3'd5;
    localparam logic [2:0] POS_MAX      = 3'd5;
    localparam logic [1:0] NUM_SCREENS  = 2'd3;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_conditioner.sv
// One push button: 2-flop synchronizer, debounce, press pulse and optional auto-repeat.
module key_conditioner
    import edit_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_RATE     = 10_000_000,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_event
);
    localparam int unsigned DEB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1, r_sync2, r_deb, r_deb_d, r_armed, r_press;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             w_differs, w_settled, w_repeat;

    // Until a released level has been seen after reset, count stable-high samples instead.
    assign w_differs = r_armed ? (r_sync2 != r_deb) : r_sync2;
    assign w_settled = w_differs && (r_deb_cnt == DEB_LAST);

    // Synchronizer, debounce counter and registered press detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_deb     <= 1'b1;
            r_deb_d   <= 1'b1;
            r_armed   <= 1'b0;
            r_press   <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            r_press <= r_deb_d & ~r_deb;
            if (!w_differs) begin
                r_deb_cnt <= '0;
            end else if (w_settled) begin
                r_deb_cnt <= '0;
                if (r_armed) begin
                    r_deb <= r_sync2;
                end else begin
                    r_armed <= 1'b1;
                end
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    generate
        if (REPEAT_EN) begin : g_rpt
            localparam int unsigned RPT_W =
                cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
            localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
            localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

            logic             r_rpt_active, r_rpt_first;
            logic [RPT_W-1:0] r_rpt_cnt;
            logic             w_rpt_hit;

            assign w_rpt_hit = r_rpt_active &&
                               (r_rpt_cnt == (r_rpt_first ? DELAY_LAST : RATE_LAST));
            // A release already visible at the synchronizer suppresses a pending repeat.
            assign w_repeat  = w_rpt_hit && !r_sync2;

            // Repeat timer measured from the previous pulse while the key stays down.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rpt_active <= 1'b0;
                    r_rpt_first  <= 1'b0;
                    r_rpt_cnt    <= '0;
                end else if (r_press) begin
                    r_rpt_active <= 1'b1;
                    r_rpt_first  <= 1'b1;
                    r_rpt_cnt    <= '0;
                end else if (r_deb) begin
                    r_rpt_active <= 1'b0;
                    r_rpt_cnt    <= '0;
                end else if (w_rpt_hit) begin
                    r_rpt_first <= 1'b0;
                    r_rpt_cnt   <= '0;
                end else if (r_rpt_active) begin
                    r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
                end else begin
                    r_rpt_cnt <= '0;
                end
            end
        end else begin : g_no_rpt
            assign w_repeat = 1'b0;
        end
    endgenerate

    assign o_event = r_press | w_repeat;

endmodule

// File: rtl/edit_controller.sv
// Button-driven RUN/EDIT controller: selects the edited digit and screen, strobes inc/dec.
module edit_controller
    import edit_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned TIMEOUT_CYCLES  = 500_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_RATE     = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       KeyMode,
    input  logic       KeyNext,
    input  logic       KeyPlus,
    input  logic       KeyMinus,
    output logic       EditMode,
    output logic [2:0] EditPos,
    output logic [1:0] screen,
    output logic       IncPulse,
    output logic       DecPulse
);
    localparam int unsigned IDLE_W = cnt_width(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    state_e            r_state, w_state_nxt;
    logic [2:0]        r_pos, w_pos_nxt;
    logic [1:0]        r_screen, w_screen_nxt;
    logic              r_inc, w_inc_nxt, r_dec, w_dec_nxt;
    logic [IDLE_W-1:0] r_idle, w_idle_nxt;
    logic              w_ev_mode, w_ev_next, w_ev_plus, w_ev_minus;

    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                      .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0))
        u_key_mode  (.clk(clk), .rst_n(reset), .i_key_n(KeyMode),  .o_event(w_ev_mode));
    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                      .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0))
        u_key_next  (.clk(clk), .rst_n(reset), .i_key_n(KeyNext),  .o_event(w_ev_next));
    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                      .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1))
        u_key_plus  (.clk(clk), .rst_n(reset), .i_key_n(KeyPlus),  .o_event(w_ev_plus));
    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                      .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1))
        u_key_minus (.clk(clk), .rst_n(reset), .i_key_n(KeyMinus), .o_event(w_ev_minus));

    // Next-state and next-output decode; KeyMode wins over everything else.
    always_comb begin
        w_state_nxt  = r_state;
        w_pos_nxt    = r_pos;
        w_screen_nxt = r_screen;
        w_inc_nxt    = 1'b0;
        w_dec_nxt    = 1'b0;
        w_idle_nxt   = r_idle;
        case (r_state)
            RUN: begin
                w_idle_nxt = '0;
                if (w_ev_mode) begin
                    w_state_nxt = EDIT;
                    w_pos_nxt   = POS_SEC_ONES;
                end else if (w_ev_next) begin
                    w_screen_nxt = (r_screen == (NUM_SCREENS - 2'd1)) ? 2'd0 : r_screen + 2'd1;
                end else begin
                    w_screen_nxt = r_screen;
                end
            end
            EDIT: begin
                if (w_ev_mode) begin
                    w_state_nxt = RUN;
                    w_idle_nxt  = '0;
                end else begin
                    if (w_ev_next) begin
                        w_pos_nxt = (r_pos == 3'd0) ? POS_MAX : r_pos - 3'd1;
                    end else begin
                        w_pos_nxt = r_pos;
                    end
                    w_inc_nxt = w_ev_plus & ~w_ev_minus;
                    w_dec_nxt = w_ev_minus & ~w_ev_plus;
                    if (w_ev_next | w_ev_plus | w_ev_minus) begin
                        w_idle_nxt = '0;
                    end else begin
                        w_idle_nxt = (r_idle == IDLE_MAX) ? IDLE_MAX : r_idle + IDLE_W'(1);
                        if (w_idle_nxt == IDLE_MAX) begin
                            w_state_nxt = RUN;
                        end else begin
                            w_state_nxt = EDIT;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_idle_nxt  = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= RUN;
            r_pos    <= POS_SEC_ONES;
            r_screen <= 2'd0;
            r_inc    <= 1'b0;
            r_dec    <= 1'b0;
            r_idle   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pos    <= w_pos_nxt;
            r_screen <= w_screen_nxt;
            r_inc    <= w_inc_nxt;
            r_dec    <= w_dec_nxt;
            r_idle   <= w_idle_nxt;
        end
    end

    assign EditMode = (r_state == EDIT);
    assign EditPos  = r_pos;
    assign screen   = r_screen;
    assign IncPulse = r_inc;
    assign DecPulse = r_dec;

endmodule
